// File: rtl/cbi980_axil_bridge.sv
// AXI4-Lite slave front end for the cbi980 core register port.
// Independent write and read engines, one core access per bus transaction.
module cbi980_axil_bridge #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [2:0]        core_wr_addr,
  output logic [31:0]       core_wr_data,
  output logic              core_wr_en,
  input  logic              core_wr_err,
  output logic [2:0]        core_rd_addr,
  output logic              core_rd_valid_in,
  input  logic [31:0]       core_rd_data,
  input  logic              core_rd_valid_out
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_EXEC  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_RESP  = 2'd3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [1:0]  wst_q, wst_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [2:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [1:0]  rst_q, rst_d;
  logic [2:0]  raddr_q, raddr_d;
  logic [31:0] rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs;

  // Address bits outside [4:2] carry no meaning for this block.
  logic unused_addr;
  assign unused_addr = ^{s_awaddr[ADDR_W-1:5], s_awaddr[1:0],
                         s_araddr[ADDR_W-1:5], s_araddr[1:0]};

  assign s_awready = (wst_q == W_IDLE) & ~aw_held_q;
  assign s_wready  = (wst_q == W_IDLE) & ~w_held_q;
  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;

  assign core_wr_en   = (wst_q == W_EXEC) & (wstrb_q == 4'hF);
  assign core_wr_addr = waddr_q;
  assign core_wr_data = wdata_q;
  assign s_bvalid     = (wst_q == W_RESP);
  assign s_bresp      = bresp_q;

  assign s_arready        = (rst_q == R_IDLE);
  assign ar_hs            = s_arvalid & s_arready;
  assign core_rd_valid_in = (rst_q == R_ISSUE);
  assign core_rd_addr     = raddr_q;
  assign s_rvalid         = (rst_q == R_RESP);
  assign s_rresp          = OKAY;
  assign s_rdata          = rdata_q;

  always_comb begin
    wst_d     = wst_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    unique case (wst_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          waddr_d   = s_awaddr[4:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        if (aw_held_d & w_held_d) wst_d = W_EXEC;
      end
      W_EXEC: begin
        // Partial strobes never reach the core; they fail on the bus.
        bresp_d = (core_wr_en & ~core_wr_err) ? OKAY : SLVERR;
        wst_d   = W_RESP;
      end
      W_RESP: begin
        if (s_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wst_d     = W_IDLE;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d   = rst_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    unique case (rst_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d = s_araddr[4:2];
          rst_d   = R_ISSUE;
        end
      end
      R_ISSUE: rst_d = R_WAIT;
      R_WAIT: begin
        if (core_rd_valid_out) begin
          rdata_d = core_rd_data;
          rst_d   = R_RESP;
        end
      end
      R_RESP: if (s_rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wst_q     <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
      rst_q     <= R_IDLE;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      wst_q     <= wst_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rst_q     <= rst_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cbi980_axil_bridge.sv
// Bench for cbi980_axil_bridge: a small core model on the register port,
// vector table, timing/reset sequences and randomized bus traffic.
module tb_cbi980_axil_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [11:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [2:0]  core_wr_addr;
  logic [31:0] core_wr_data;
  logic        core_wr_en;
  logic        core_wr_err;
  logic [2:0]  core_rd_addr;
  logic        core_rd_valid_in;
  logic [31:0] core_rd_data;
  logic        core_rd_valid_out;

  cbi980_axil_bridge #(.ADDR_W(12)) dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_wr_en(core_wr_en), .core_wr_err(core_wr_err),
    .core_rd_addr(core_rd_addr), .core_rd_valid_in(core_rd_valid_in),
    .core_rd_data(core_rd_data), .core_rd_valid_out(core_rd_valid_out)
  );

  always #5 clk = ~clk;

  // Core stand-in: idx0 = read-only version reg, idx6 = DIN FIFO pop,
  // idx6/7 and idx0 reject writes, idx1..5 are plain storage.
  localparam logic [31:0] VERSION = 32'hcb19_9800;
  logic [31:0] core_regs [8] = '{default: 32'h0};
  logic [31:0] din_fifo [$] = '{32'hA000_0001, 32'hA000_0002,
                               32'hA000_0003, 32'hA000_0004,
                               32'hA000_0005, 32'hA000_0006};
  int wr_pulses = 0;
  int rd_pulses = 0;

  assign core_wr_err = core_wr_en &&
                       (core_wr_addr == 3'd0 || core_wr_addr >= 3'd6);

  initial core_rd_valid_out = 1'b0;
  initial core_rd_data = 32'h0;

  always @(posedge clk) begin
    if (core_wr_en) wr_pulses <= wr_pulses + 1;
    if (core_rd_valid_in) rd_pulses <= rd_pulses + 1;
    if (core_wr_en && !core_wr_err) core_regs[core_wr_addr] <= core_wr_data;
    core_rd_valid_out <= core_rd_valid_in;
    if (core_rd_valid_in) begin
      if (core_rd_addr == 3'd0) core_rd_data <= VERSION;
      else if (core_rd_addr == 3'd6)
        core_rd_data <= (din_fifo.size() > 0) ? din_fifo.pop_front() : 32'h0;
      else core_rd_data <= core_regs[core_rd_addr];
    end
  end

  // Bus-level expectations.
  logic [31:0] exp_regs [8];
  logic [31:0] exp_din [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_awready"}, 32'(s_awready), 32'd1);
    chk({p, "_wready"}, 32'(s_wready), 32'd1);
    chk({p, "_arready"}, 32'(s_arready), 32'd1);
    chk({p, "_bvalid"}, 32'(s_bvalid), 32'd0);
    chk({p, "_rvalid"}, 32'(s_rvalid), 32'd0);
    chk({p, "_bresp"}, 32'(s_bresp), 32'd0);
    chk({p, "_rresp"}, 32'(s_rresp), 32'd0);
    chk({p, "_rdata"}, s_rdata, 32'd0);
    chk({p, "_wr_en"}, 32'(core_wr_en), 32'd0);
    chk({p, "_rd_vin"}, 32'(core_rd_valid_in), 32'd0);
    chk({p, "_wr_addr"}, 32'(core_wr_addr), 32'd0);
    chk({p, "_rd_addr"}, 32'(core_rd_addr), 32'd0);
    chk({p, "_wr_data"}, core_wr_data, 32'd0);
  endtask

  task automatic send_aw(input logic [11:0] a, input int dly);
    logic r;
    repeat (dly) cyc();
    s_awaddr  = a;
    s_awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = s_awready;
      cyc();
      if (r) begin
        s_awvalid = 1'b0;
        return;
      end
    end
    s_awvalid = 1'b0;
    timeout("aw");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                        input int dly);
    logic r;
    repeat (dly) cyc();
    s_wdata  = d;
    s_wstrb  = s;
    s_wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = s_wready;
      cyc();
      if (r) begin
        s_wvalid = 1'b0;
        return;
      end
    end
    s_wvalid = 1'b0;
    timeout("w");
  endtask

  task automatic send_ar(input logic [11:0] a);
    logic r;
    s_araddr  = a;
    s_arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = s_arready;
      cyc();
      if (r) begin
        s_arvalid = 1'b0;
        return;
      end
    end
    s_arvalid = 1'b0;
    timeout("ar");
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int awd, input int wd,
                           output logic [1:0] resp);
    int i;
    fork
      send_aw(a, awd);
      send_w(d, s, wd);
    join
    for (i = 0; i < 50 && !s_bvalid; i++) cyc();
    if (!s_bvalid) begin
      timeout("b");
      resp = 2'bxx;
      return;
    end
    resp     = s_bresp;
    s_bready = 1'b1;
    cyc();
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input int rdly,
                          output logic [31:0] first, output logic [31:0] last,
                          output logic [1:0] resp, output logic vld);
    int i;
    send_ar(a);
    for (i = 0; i < 50 && !s_rvalid; i++) cyc();
    if (!s_rvalid) begin
      timeout("r");
      first = 'x;
      last  = 'x;
      resp  = 'x;
      vld   = 1'b0;
      return;
    end
    first = s_rdata;
    repeat (rdly) cyc();
    vld      = s_rvalid;
    last     = s_rdata;
    resp     = s_rresp;
    s_rready = 1'b1;
    cyc();
    s_rready = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input logic [2:0] idx);
    if (idx == 3'd0) return VERSION;
    if (idx == 3'd6) return (exp_din.size() > 0) ? exp_din.pop_front() : 32'h0;
    return exp_regs[idx];
  endfunction

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd;
    int          wd;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_pulse;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [1:0]  resp;
    logic [31:0] d0, d1, wv;
    logic        vld;
    int          wp0, rp0;

    for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
    exp_din = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                32'hA000_0004, 32'hA000_0005, 32'hA000_0006};

    vecs[0] = '{1, 12'h008, 32'h0000_0030, 4'hF, 0, 0, 2'b00, 0, 1};
    vecs[1] = '{1, 12'h000, 32'h0000_1234, 4'hF, 1, 0, 2'b10, 0, 1};
    vecs[2] = '{1, 12'h010, 32'h0000_dead, 4'h3, 0, 0, 2'b10, 0, 0};
    vecs[3] = '{0, 12'h008, 0, 0, 0, 0, 2'b00, 32'h0000_0030, 1};
    vecs[4] = '{0, 12'h000, 0, 0, 0, 0, 2'b00, 32'hcb19_9800, 1};
    vecs[5] = '{1, 12'h014, 32'h0000_55aa, 4'hF, 2, 0, 2'b00, 0, 1};
    vecs[6] = '{0, 12'hF17, 0, 0, 0, 0, 2'b00, 32'h0000_55aa, 1};
    vecs[7] = '{0, 12'h010, 0, 0, 0, 0, 2'b00, 32'h0, 1};
    vecs[8] = '{0, 12'h00c, 0, 0, 0, 0, 2'b00, 32'h0, 1};

    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0;
    s_wvalid = 0; s_bready = 0; s_araddr = '0; s_arvalid = 0;
    s_rready = 0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rstn = 1'b1;
    cyc();

    foreach (vecs[k]) begin
      wp0 = wr_pulses;
      rp0 = rd_pulses;
      if (vecs[k].wr) begin
        axi_write(vecs[k].addr, vecs[k].data, vecs[k].strb,
                  vecs[k].awd, vecs[k].wd, resp);
        chk($sformatf("vec%0d_bresp", k), 32'(resp), 32'(vecs[k].exp_resp));
        chk($sformatf("vec%0d_wpulse", k), wr_pulses - wp0,
            vecs[k].exp_pulse);
        if (vecs[k].exp_resp == 2'b00)
          exp_regs[vecs[k].addr[4:2]] = vecs[k].data;
      end else begin
        axi_read(vecs[k].addr, 0, d0, d1, resp, vld);
        chk($sformatf("vec%0d_rdata", k), d1, vecs[k].exp_rdata);
        chk($sformatf("vec%0d_rresp", k), 32'(resp), 32'd0);
        chk($sformatf("vec%0d_rpulse", k), rd_pulses - rp0,
            vecs[k].exp_pulse);
      end
    end

    // Write timing: AW+W same cycle, bready held high.
    wp0 = wr_pulses;
    s_awaddr = 12'h008; s_awvalid = 1; s_wdata = 32'h30; s_wstrb = 4'hF;
    s_wvalid = 1; s_bready = 1;
    cyc();
    s_awvalid = 0; s_wvalid = 0;
    chk("wt_wr_en", 32'(core_wr_en), 32'd1);
    chk("wt_wr_addr", 32'(core_wr_addr), 32'd2);
    chk("wt_wr_data", core_wr_data, 32'h30);
    chk("wt_bvalid_early", 32'(s_bvalid), 32'd0);
    cyc();
    chk("wt_wr_en_off", 32'(core_wr_en), 32'd0);
    chk("wt_bvalid", 32'(s_bvalid), 32'd1);
    chk("wt_bresp", 32'(s_bresp), 32'd0);
    chk("wt_awready_busy", 32'(s_awready), 32'd0);
    cyc();
    s_bready = 0;
    chk("wt_bvalid_done", 32'(s_bvalid), 32'd0);
    chk("wt_awready_again", 32'(s_awready), 32'd1);
    chk("wt_pulses", wr_pulses - wp0, 1);
    exp_regs[2] = 32'h30;

    // Read timing with a 5-cycle rready stall.
    rp0 = rd_pulses;
    s_araddr = 12'h000; s_arvalid = 1;
    cyc();
    s_arvalid = 0;
    chk("rt_rd_vin", 32'(core_rd_valid_in), 32'd1);
    chk("rt_rd_addr", 32'(core_rd_addr), 32'd0);
    cyc();
    chk("rt_rd_vin_off", 32'(core_rd_valid_in), 32'd0);
    chk("rt_rvalid_early", 32'(s_rvalid), 32'd0);
    cyc();
    chk("rt_rvalid", 32'(s_rvalid), 32'd1);
    chk("rt_rdata", s_rdata, VERSION);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("rt_stall%0d_rvalid", i), 32'(s_rvalid), 32'd1);
      chk($sformatf("rt_stall%0d_rdata", i), s_rdata, VERSION);
    end
    chk("rt_rresp", 32'(s_rresp), 32'd0);
    s_rready = 1;
    cyc();
    s_rready = 0;
    chk("rt_rvalid_done", 32'(s_rvalid), 32'd0);
    chk("rt_pulses", rd_pulses - rp0, 1);

    // DIN FIFO reads back to back, write to idx4 running alongside.
    rp0 = rd_pulses;
    begin
      logic [31:0] e0, e1, g0, g1;
      logic [1:0]  wr_resp;
      e0 = exp_read(3'd6);
      e1 = exp_read(3'd6);
      fork
        begin
          axi_read(12'h018, 0, d0, g0, resp, vld);
          axi_read(12'h018, 0, d0, g1, resp, vld);
        end
        axi_write(12'h010, 32'hfeed_0010, 4'hF, 0, 0, wr_resp);
      join
      chk("fifo_rd0", g0, e0);
      chk("fifo_rd1", g1, e1);
      chk("fifo_pulses", rd_pulses - rp0, 2);
      chk("conc_bresp", 32'(wr_resp), 32'd0);
      exp_regs[4] = 32'hfeed_0010;
      axi_read(12'h010, 0, d0, d1, resp, vld);
      chk("conc_readback", d1, 32'hfeed_0010);
    end

    // Reset while the read engine waits on the core.
    rp0 = rd_pulses;
    s_araddr = 12'h004; s_arvalid = 1;
    cyc();
    s_arvalid = 0;
    cyc();
    rstn = 0;
    #1;
    check_reset("rrst");
    cyc();
    cyc();
    chk("rrst_rvalid_held", 32'(s_rvalid), 32'd0);
    rstn = 1;
    cyc();
    chk("rrst_pulses", rd_pulses - rp0, 1);
    chk("rrst_arready", 32'(s_arready), 32'd1);

    // Reset while bvalid is waiting on bready.
    wp0 = wr_pulses;
    wv = 32'h3333_abcd;
    fork
      send_aw(12'h00c, 0);
      send_w(wv, 4'hF, 0);
    join
    for (int i = 0; i < 50 && !s_bvalid; i++) cyc();
    cyc();
    chk("wrst_bvalid_pre", 32'(s_bvalid), 32'd1);
    rstn = 0;
    #1;
    check_reset("wrst");
    cyc();
    rstn = 1;
    cyc();
    chk("wrst_pulses", wr_pulses - wp0, 1);
    exp_regs[3] = wv;
    axi_write(12'h01c, 32'h77, 4'hF, 0, 1, resp);
    chk("wrst_after_resp", 32'(resp), 32'd2);
    axi_write(12'h008, 32'h0000_0042, 4'hF, 1, 0, resp);
    chk("wrst_after_ok", 32'(resp), 32'd0);
    exp_regs[2] = 32'h42;
    axi_read(12'h004, 0, d0, d1, resp, vld);
    chk("rrst_after_rd", d1, exp_regs[1]);

    // Randomized traffic against the bus-level expectation.
    for (int t = 0; t < 80; t++) begin
      logic [2:0]  idx;
      logic [11:0] a;
      logic [31:0] d, e;
      logic [3:0]  s;
      logic [1:0]  er;
      int          rdly;
      idx = 3'($urandom_range(0, 7));
      a = {7'($urandom), idx, 2'($urandom)};
      wp0 = wr_pulses;
      rp0 = rd_pulses;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
        er = (s == 4'hF && idx >= 3'd1 && idx <= 3'd5) ? 2'b00 : 2'b10;
        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), resp);
        chk($sformatf("rnd%0d_bresp", t), 32'(resp), 32'(er));
        chk($sformatf("rnd%0d_wpulse", t), wr_pulses - wp0,
            (s == 4'hF) ? 1 : 0);
        if (er == 2'b00) exp_regs[idx] = d;
      end else begin
        rdly = $urandom_range(0, 3);
        e = exp_read(idx);
        axi_read(a, rdly, d0, d1, resp, vld);
        chk($sformatf("rnd%0d_rdata", t), d1, e);
        chk($sformatf("rnd%0d_stable", t), d0, e);
        chk($sformatf("rnd%0d_vld", t), 32'(vld), 32'd1);
        chk($sformatf("rnd%0d_rpulse", t), rd_pulses - rp0, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
